fp_unit_share_arbiter: RTL and testbench

- Shares one pipelined floating-point arithmetic unit (an `f_mult`, `f_add` or `f_sub` wrapper instance) among N_REQ independent requesters.
- Each requester has AXI-Stream-style operand and result channels. The arbiter issues at most one operation per cycle, chosen round-robin, and tags each issued operation with its requester ID.
- The unit returns results in order with no backpressure. The arbiter routes each result to a per-requester output FIFO.
- Per-requester credits guarantee that no result is ever dropped.

---
 rtl/fp_share_pkg.sv | 31 +++
 rtl/fp_share_fifo.sv | 62 ++++++
 rtl/fp_unit_share_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_fp_unit_share_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_share_pkg.sv
// Shared types, default sizing and the round-robin pick helper for the FP unit share arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_share_pkg;

    localparam int DEF_N_REQ        = 4;
    localparam int DEF_FLEN         = 64;
    localparam int DEF_OUT_DEPTH    = 4;
    localparam int DEF_MAX_INFLIGHT = 16;

    // Widest requester count the pick helper handles.
    localparam int MAX_REQ = 8;

    localparam int REQ_ID_W = (DEF_N_REQ > 1) ? $clog2(DEF_N_REQ) : 1;
    typedef logic [REQ_ID_W-1:0] req_id_t;

    // Index of the first set bit of elig, scanning ptr, ptr+1, ... modulo n; -1 when none is set.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] elig, input int ptr, input int n);
        int pick;
        pick = -1;
        for (int k = 0; k < MAX_REQ; k++) begin
            for (int j = 0; j < MAX_REQ; j++) begin
                if (pick < 0 && k < n && j == (ptr + k) % n && elig[j]) begin
                    pick = j;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fp_share_fifo.sv
// Generic synchronous FIFO with registered storage and head-of-queue output.
// Latency: a push is visible at head one cycle later.
// Backpressure: push ignored while full (even with a pop that cycle); pop ignored while empty.
module fp_share_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset; only occupancy is meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/fp_unit_share_arbiter.sv
// Round-robin share of one in-order pipelined FP unit among N_REQ requesters, results routed by tag.
// Latency: issue is combinational; result visible on rsp_vld unit latency + 1 cycles after issue.
// Backpressure: per-requester credits (= output FIFO depth) hold off issue, so results never drop.
module fp_unit_share_arbiter
    import fp_share_pkg::*;
#(
    parameter int N_REQ        = DEF_N_REQ,
    parameter int FLEN         = DEF_FLEN,
    parameter int OUT_DEPTH    = DEF_OUT_DEPTH,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_vld,
    output logic [N_REQ-1:0]      req_rdy,
    input  logic [N_REQ*FLEN-1:0] req_a,
    input  logic [N_REQ*FLEN-1:0] req_b,
    output logic [N_REQ-1:0]      rsp_vld,
    input  logic [N_REQ-1:0]      rsp_rdy,
    output logic [N_REQ*FLEN-1:0] rsp_res,
    output logic                  unit_up_valid,
    output logic [FLEN-1:0]       unit_a,
    output logic [FLEN-1:0]       unit_b,
    input  logic                  unit_down_valid,
    input  logic [FLEN-1:0]       unit_res,
    output logic                  err
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW   = $clog2(OUT_DEPTH + 1);

    logic [ID_W-1:0]    rr_ptr;
    logic [CW-1:0]      credit [N_REQ];
    logic [N_REQ-1:0]   elig;
    logic [MAX_REQ-1:0] elig_pad;
    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_id;
    int                 pick;
    logic               issue;

    logic               tag_full;
    logic               tag_empty;
    logic [ID_W-1:0]    tag_head;
    logic               ret_ok;
    logic               ret_armed;
    logic               err_q;

    logic [N_REQ-1:0]   out_push;
    logic [N_REQ-1:0]   out_pop;
    logic [N_REQ-1:0]   out_full;
    logic [N_REQ-1:0]   out_empty;
    logic [FLEN-1:0]    out_head [N_REQ];

    // Eligibility: valid operand, spare credit, and room to record the tag.
    always_comb begin
        elig     = '0;
        elig_pad = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_vld[i] && (credit[i] < CW'(OUT_DEPTH)) && !tag_full;
        end
        elig_pad[N_REQ-1:0] = elig;
    end

    // Round-robin grant starting at rr_ptr; nothing is granted while in reset.
    always_comb begin
        pick     = rr_pick(elig_pad, int'(rr_ptr), N_REQ);
        issue    = (pick >= 0) && !rst;
        grant_id = ID_W'(pick);
        grant    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = issue && (grant_id == ID_W'(i));
        end
    end

    assign req_rdy       = grant;
    assign unit_up_valid = issue;

    // Forward the granted requester's operands to the unit in the same cycle.
    always_comb begin
        unit_a = '0;
        unit_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                unit_a = req_a[i*FLEN +: FLEN];
                unit_b = req_b[i*FLEN +: FLEN];
            end
        end
    end

    // Pointer moves past the winner; holds when nobody is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Credit counts in-flight plus buffered results; issue and drain together cancel.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (rst) begin
                credit[i] <= '0;
            end else if (grant[i] && !out_pop[i]) begin
                credit[i] <= credit[i] + 1'b1;
            end else if (!grant[i] && out_pop[i]) begin
                credit[i] <= credit[i] - 1'b1;
            end
        end
    end

    fp_share_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (issue),
        .push_dat (grant_id),
        .pop      (ret_ok),
        .full     (tag_full),
        .empty    (tag_empty),
        .head     (tag_head)
    );

    assign ret_ok = unit_down_valid && !tag_empty;

    // Results left in the unit across a reset must not flag an error; stay quiet until the next issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_armed <= 1'b0;
        end else if (issue) begin
            ret_armed <= 1'b1;
        end
    end

    // Route each result to the output FIFO named by the oldest tag; drain on handshake.
    always_comb begin
        out_push = '0;
        out_pop  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            out_push[i] = ret_ok && (tag_head == ID_W'(i));
            out_pop[i]  = !out_empty[i] && rsp_rdy[i];
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_out
        fp_share_fifo #(
            .WIDTH (FLEN),
            .DEPTH (OUT_DEPTH)
        ) u_out_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (out_push[g]),
            .push_dat (unit_res),
            .pop      (out_pop[g]),
            .full     (out_full[g]),
            .empty    (out_empty[g]),
            .head     (out_head[g])
        );
    end

    assign rsp_vld = ~out_empty;

    // Pack FIFO heads onto the result bus.
    always_comb begin
        rsp_res = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_res[i*FLEN +: FLEN] = out_head[i];
        end
    end

    // Sticky error: orphan result, or a write into a full output FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((unit_down_valid && tag_empty && ret_armed) || |(out_push & out_full)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_fp_unit_share_arbiter.sv
// Bench for the FP unit share arbiter with a 3-stage multiply unit model and a queue-based reference.
// Latency: n/a.
// Backpressure: driven by directed rsp_rdy patterns.
module tb_fp_unit_share_arbiter;

    localparam int N  = 4;
    localparam int FL = 64;
    localparam int OD = 4;
    localparam int MI = 16;
    localparam int L  = 3;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_rdy;
    logic [N*FL-1:0] req_a;
    logic [N*FL-1:0] req_b;
    logic [N-1:0]    rsp_vld;
    logic [N-1:0]    rsp_rdy;
    logic [N*FL-1:0] rsp_res;
    logic            unit_up_valid;
    logic [FL-1:0]   unit_a;
    logic [FL-1:0]   unit_b;
    logic            unit_down_valid;
    logic [FL-1:0]   unit_res;
    logic            err;
    logic            inject;

    int n_pass;
    int n_total;

    fp_unit_share_arbiter #(
        .N_REQ        (N),
        .FLEN         (FL),
        .OUT_DEPTH    (OD),
        .MAX_INFLIGHT (MI)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_vld         (req_vld),
        .req_rdy         (req_rdy),
        .req_a           (req_a),
        .req_b           (req_b),
        .rsp_vld         (rsp_vld),
        .rsp_rdy         (rsp_rdy),
        .rsp_res         (rsp_res),
        .unit_up_valid   (unit_up_valid),
        .unit_a          (unit_a),
        .unit_b          (unit_b),
        .unit_down_valid (unit_down_valid),
        .unit_res        (unit_res),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared f_mult stand-in: fixed 3-cycle pipeline, never reset, no backpressure.
    logic [L-1:0]  pv = '0;
    logic [FL-1:0] pd [L];
    always @(posedge clk) begin
        pv[0] <= unit_up_valid;
        pd[0] <= $realtobits($bitstoreal(unit_a) * $bitstoreal(unit_b));
        for (int s = 1; s < L; s++) begin
            pv[s] <= pv[s-1];
            pd[s] <= pd[s-1];
        end
    end
    assign unit_down_valid = pv[L-1] | inject;
    assign unit_res        = pd[L-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: rotating priority, credit counts, an in-order tag queue and per-requester result queues.
    int          m_ptr;
    int          m_cred [N];
    int          m_tags [$];
    logic [63:0] m_out [N][$];
    bit          m_armed;
    bit          m_err;

    always @(negedge clk) begin
        int g;
        int t;
        int idx;
        int pre_sz [N];
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        if (rst) begin
            m_ptr = 0;
            m_tags.delete();
            for (int i = 0; i < N; i++) begin
                m_cred[i] = 0;
                m_out[i].delete();
            end
            m_armed = 0;
            m_err = 0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_vld[idx] && m_cred[idx] < OD && m_tags.size() < MI) g = idx;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_rdy", req_rdy, exp_rdy);
            check("unit_up_valid", unit_up_valid, g >= 0);
            if (g >= 0) begin
                check("unit_a", unit_a, req_a[g*FL +: FL]);
                check("unit_b", unit_b, req_b[g*FL +: FL]);
            end
            exp_rv = '0;
            for (int i = 0; i < N; i++) begin
                pre_sz[i] = m_out[i].size();
                if (pre_sz[i] > 0) begin
                    exp_rv[i] = 1'b1;
                    check("rsp_res", rsp_res[i*FL +: FL], m_out[i][0]);
                end
            end
            check("rsp_vld", rsp_vld, exp_rv);
            check("err", err, m_err);
            // advance to the state after the coming edge
            for (int i = 0; i < N; i++) begin
                if (pre_sz[i] > 0 && rsp_rdy[i]) begin
                    void'(m_out[i].pop_front());
                    m_cred[i]--;
                end
            end
            if (unit_down_valid) begin
                if (m_tags.size() > 0) begin
                    t = m_tags.pop_front();
                    if (pre_sz[t] >= OD) m_err = 1;
                    else m_out[t].push_back(unit_res);
                end else if (m_armed) begin
                    m_err = 1;
                end
            end
            if (g >= 0) begin
                m_tags.push_back(g);
                m_cred[g]++;
                m_ptr = (g + 1) % N;
                m_armed = 1;
            end
        end
    end

    // Event counters used by the directed scenarios.
    int gcnt [N];
    int rcnt [N];
    int upc;
    int glog [$];
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_rdy[i]) begin
                    gcnt[i]++;
                    glog.push_back(i);
                end
                if (rsp_vld[i] && rsp_rdy[i]) rcnt[i]++;
            end
            if (unit_up_valid) upc++;
        end
    end

    int opn [N];
    int g0 [N];
    int r0 [N];
    int u0;
    int gl0;
    int bad;

    task automatic set_op(input int i);
        req_a[i*FL +: FL] = $realtobits(real'(i * 1000 + opn[i] + 1));
        req_b[i*FL +: FL] = $realtobits(real'(i + 2));
    endtask

    task automatic set_all_ops();
        for (int i = 0; i < N; i++) begin
            opn[i] = 0;
            set_op(i);
        end
    endtask

    // Each cycle: note who was granted, then present that requester's next operand.
    task automatic run_cycles(input int n);
        logic [N-1:0] r;
        repeat (n) begin
            @(negedge clk);
            r = req_rdy;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    opn[i]++;
                    set_op(i);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_vld = '0;
        rsp_rdy = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic snap();
        g0 = gcnt;
        r0 = rcnt;
        u0 = upc;
        gl0 = glog.size();
    endtask

    // One operation from requester idx; checks same-cycle grant, latency and result value.
    task automatic single_op(input int idx, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] exp, input string name);
        logic [N-1:0] one;
        int lat;
        one = '0;
        one[idx] = 1'b1;
        req_a[idx*FL +: FL] = a;
        req_b[idx*FL +: FL] = b;
        req_vld = one;
        rsp_rdy = '1;
        @(negedge clk);
        check({name, "_grant"}, req_rdy, one);
        @(posedge clk);
        #1;
        req_vld = '0;
        lat = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (lat == 0 && rsp_vld != '0) begin
                lat = cyc;
                check({name, "_vld"}, rsp_vld, one);
                check({name, "_res"}, rsp_res[idx*FL +: FL], exp);
            end
        end
        check({name, "_latency"}, lat, L + 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        inject = 1'b0;
        req_a = '0;
        req_b = '0;
        rst = 1'b1;
        req_vld = '0;
        rsp_rdy = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_rdy", req_rdy, 0);
        check("reset_rsp_vld", rsp_vld, 0);
        check("reset_up_valid", unit_up_valid, 0);
        check("reset_err", err, 0);
        @(posedge clk);
        #1;

        // 2.0 * 3.0 = 6.0 on requester 1
        single_op(1, 64'h4000000000000000, 64'h4008000000000000, 64'h4018000000000000, "single");

        // all four requesters, no backpressure
        do_reset();
        set_all_ops();
        req_vld = '1;
        rsp_rdy = '1;
        snap();
        run_cycles(100);
        req_vld = '0;
        check("fair_up_cycles", upc - u0, 100);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (glog[gl0 + k] != k % N) bad++;
        end
        check("fair_order_errors", bad, 0);
        run_cycles(10);
        for (int i = 0; i < N; i++) begin
            check("fair_grants", gcnt[i] - g0[i], 25);
            check("fair_results", rcnt[i] - r0[i], 25);
        end

        // requester 2 blocked on its result port
        do_reset();
        set_all_ops();
        req_vld = '1;
        rsp_rdy = 4'b1011;
        snap();
        run_cycles(30);
        check("stall_grants2", gcnt[2] - g0[2], 4);
        check("stall_others", (gcnt[0] - g0[0]) + (gcnt[1] - g0[1]) + (gcnt[3] - g0[3]), 26);
        @(negedge clk);
        check("stall_rdy2", req_rdy[2], 0);
        check("stall_served", unit_up_valid, 1);
        @(posedge clk);
        #1;
        rsp_rdy = '1;
        snap();
        run_cycles(20);
        check("stall_drained4", (rcnt[2] - r0[2]) >= 4, 1);
        check("stall_resumed", (gcnt[2] - g0[2]) >= 1, 1);
        req_vld = '0;
        run_cycles(10);

        // requester 0 full of credit, drain and request in the same cycle
        do_reset();
        set_all_ops();
        req_vld = 4'b0001;
        rsp_rdy = '0;
        snap();
        run_cycles(12);
        check("simul_grants", gcnt[0] - g0[0], 4);
        rsp_rdy = 4'b0001;
        @(negedge clk);
        check("simul_rdy_full", req_rdy, 0);
        check("simul_vld", rsp_vld, 4'b0001);
        @(posedge clk);
        #1;
        rsp_rdy = '0;
        @(negedge clk);
        check("simul_rdy_next", req_rdy, 4'b0001);
        @(posedge clk);
        #1;
        opn[0]++;
        set_op(0);
        req_vld = '0;
        rsp_rdy = '1;
        run_cycles(12);
        check("simul_total_grants", gcnt[0] - g0[0], 5);
        check("simul_total_results", rcnt[0] - r0[0], 5);

        // reset with six operations outstanding
        do_reset();
        set_all_ops();
        req_vld = '1;
        rsp_rdy = '0;
        snap();
        run_cycles(6);
        check("mid_issued", glog.size() - gl0, 6);
        rst = 1'b1;
        req_vld = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_req_rdy", req_rdy, 0);
        check("mid_rsp_vld", rsp_vld, 0);
        check("mid_up_valid", unit_up_valid, 0);
        check("mid_err", err, 0);
        rsp_rdy = '1;
        repeat (6) @(negedge clk);
        check("mid_late_err", err, 0);
        check("mid_late_vld", rsp_vld, 0);
        @(posedge clk);
        #1;
        // 2.5 * 2.0 = 5.0 on requester 3
        single_op(3, 64'h4004000000000000, 64'h4000000000000000, 64'h4014000000000000, "post");

        // orphan result with nothing in flight
        inject = 1'b1;
        @(posedge clk);
        #1;
        inject = 1'b0;
        @(negedge clk);
        check("proto_err_set", err, 1);
        repeat (5) @(negedge clk);
        check("proto_err_held", err, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("proto_err_cleared", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
